// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package rr_mux_arb_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_t;

    // Wrap-around increment of a requester index within [0, n-1].
    function automatic int next_ptr(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester-side and consumer-side handshake bundle of the arbiter.
interface rr_mux_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    localparam int SRC_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [SRC_W-1:0]       out_src;
    logic                   out_ready;

    // Environment side: requesters and consumer.
    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_src
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational round-robin picker: rotate requests so prio_ptr sits at
// bit 0, priority-encode the lowest set bit, then rotate the index back.
module rr_pick #(
    parameter int N_REQ = 4,
    localparam int PW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    prio_ptr,
    output logic             any_req,
    output logic [PW-1:0]    winner
);
    localparam logic [PW:0] N_W = (PW+1)'(N_REQ);

    logic [N_REQ-1:0] rot;
    logic [PW-1:0]    off;
    logic [PW:0]      sum;

    // Rotate, find the first request at or after the pointer, map back to an index.
    always_comb begin
        rot = N_REQ'({req, req} >> prio_ptr);
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = PW'(i);
        end
        sum = {1'b0, prio_ptr} + {1'b0, off};
        if (sum >= N_W) sum = sum - N_W;
        winner  = sum[PW-1:0];
        any_req = |req;
    end
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter feeding a single-entry registered output channel.
// Drain and refill may happen on the same edge, giving one word per cycle.
module rr_mux_arbiter
    import rr_mux_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_mux_arbiter_if.slave      bus
);
    localparam int SRC_W = $clog2(N_REQ);

    arb_state_t       state_q, state_d;
    logic [SRC_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SRC_W-1:0] src_q, src_d;

    logic             any_req;
    logic [SRC_W-1:0] winner;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] words [N_REQ];
    logic [WIDTH-1:0] sel_data;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req      (bus.req_valid),
        .prio_ptr (ptr_q),
        .any_req  (any_req),
        .winner   (winner)
    );

    // Unpack the requester words and select the winner's word.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            words[i] = bus.req_data[i*WIDTH +: WIDTH];
        end
        sel_data = words[winner];
    end

    // Grant generation; no grant is visible while reset is held.
    always_comb begin
        load_en       = (state_q == ST_EMPTY) || bus.out_ready;
        xfer          = load_en && any_req && rst_n;
        bus.req_ready = '0;
        if (xfer) bus.req_ready[winner] = 1'b1;
    end

    // Next-state logic: load a winner, drain on accept, hold under backpressure.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        src_d   = src_q;
        case (state_q)
            ST_EMPTY: if (xfer) state_d = ST_FULL;
            ST_FULL:  if (bus.out_ready && !any_req) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
        if (xfer) begin
            data_d = sel_data;
            src_d  = winner;
            ptr_d  = SRC_W'(next_ptr(int'(winner), N_REQ));
        end
    end

    // State, pointer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_data  = data_q;
    assign bus.out_src   = src_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter with a behavioural round-robin model.
module tb_rr_mux_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // Reference model state
    int   m_full, m_data, m_src, m_ptr, m_g;
    logic [N-1:0] exp_ready;
    logic         exp_valid;
    logic [W-1:0] exp_data;
    logic [1:0]   exp_src;

    rr_mux_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    rr_mux_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_full = 0; m_data = 0; m_src = 0; m_ptr = 0; m_g = -1;
    endtask

    // Expected grant: circular scan from the pointer, only when the slot can load.
    task automatic model_eval();
        m_g = -1;
        if (m_full == 0 || bus.out_ready) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (m_g < 0 && bus.req_valid[i]) m_g = i;
            end
        end
        exp_ready = (m_g >= 0) ? N'(1 << m_g) : '0;
        exp_valid = (m_full != 0);
        exp_data  = W'(m_data);
        exp_src   = 2'(m_src);
    endtask

    task automatic model_edge();
        if (m_g >= 0) begin
            m_full = 1;
            m_data = int'(bus.req_data[m_g*W +: W]);
            m_src  = m_g;
            m_ptr  = (m_g + 1) % N;
        end else if (m_full != 0 && bus.out_ready) begin
            m_full = 0;
        end
    endtask

    // Apply inputs just after an edge and let combinational outputs settle.
    task automatic settle(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic ordy);
        bus.req_valid = v;
        bus.req_data  = d;
        bus.out_ready = ordy;
        model_eval();
        #3;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = '0; bus.req_data = '0; bus.out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = '0; bus.req_data = '0; bus.out_ready = 1'b0;
        model_reset();
        #2;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.req_ready !== 4'b0000 || bus.out_src !== 2'd0 || bus.out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_state valid=%b ready=%b src=%0d data=%h required 0 0000 0 00",
                     bus.out_valid, bus.req_ready, bus.out_src, bus.out_data);
        end
        bus.req_valid = 4'b1111; bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_no_grant ready=%b required 0000", bus.req_ready);
        end
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        settle(4'b0001, {24'h0, 8'hA5}, 1'b1);
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant ready=%b required 0001", bus.req_ready);
        end
        tick();
        settle(4'b0000, '0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.out_src !== 2'd0) begin
            errors++;
            $display("FAIL single_output valid=%b data=%h src=%0d required 1 a5 0",
                     bus.out_valid, bus.out_data, bus.out_src);
        end
        tick();
        // Pointer is now 1: with 0 and 1 both valid, requester 1 must win.
        settle(4'b0011, {16'h0, 8'h22, 8'h11}, 1'b1);
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL single_ptr_advanced ready=%b required 0010", bus.req_ready);
        end
        settle(4'b0000, '0, 1'b1);
        tick();
    endtask

    task automatic test_round_robin();
        int prev;
        do_reset();
        prev = -1;
        for (int k = 0; k < 6; k++) begin
            settle(4'b1111, {8'h44, 8'h33, 8'h22, 8'h11} + (N*W)'(k), 1'b1);
            checks++;
            if (bus.req_ready !== N'(1 << (k % N))) begin
                errors++;
                $display("FAIL rr_grant step=%0d ready=%b required %b", k, bus.req_ready, N'(1 << (k % N)));
            end
            if (prev >= 0) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_src !== 2'(prev)) begin
                    errors++;
                    $display("FAIL rr_src step=%0d valid=%b src=%0d required 1 %0d", k, bus.out_valid, bus.out_src, prev);
                end
            end
            prev = k % N;
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        // Last grant in the burst was requester 1; fill so the last winner leaves ptr=1.
        settle(4'b0001, {24'h0, 8'h5C}, 1'b1);
        tick();
        held = bus.out_data;
        checks++;
        if (held !== 8'h5C) begin
            errors++;
            $display("FAIL bp_fill data=%h required 5c", held);
        end
        for (int k = 0; k < 3; k++) begin
            settle(4'b0110, {8'h0, 8'hCC, 8'hBB, 8'h0}, 1'b0);
            checks++;
            if (bus.req_ready !== 4'b0000 || bus.out_valid !== 1'b1 || bus.out_data !== 8'h5C) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d ready=%b valid=%b data=%h required 0000 1 5c",
                         k, bus.req_ready, bus.out_valid, bus.out_data);
            end
            tick();
        end
        settle(4'b0110, {8'h0, 8'hCC, 8'hBB, 8'h0}, 1'b1);
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_release ready=%b required 0010", bus.req_ready);
        end
        tick();
        checks++;
        if (bus.out_data !== 8'hBB || bus.out_src !== 2'd1) begin
            errors++;
            $display("FAIL bp_release_out data=%h src=%0d required bb 1", bus.out_data, bus.out_src);
        end
    endtask

    task automatic test_wrap();
        // Pointer is 2; granting requester 2 moves it to 3.
        settle(4'b0100, {8'h0, 8'h77, 16'h0}, 1'b1);
        tick();
        settle(4'b1001, {8'hD3, 16'h0, 8'hD0}, 1'b1);
        checks++;
        if (bus.req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_first ready=%b required 1000", bus.req_ready);
        end
        tick();
        settle(4'b1001, {8'hD3, 16'h0, 8'hD0}, 1'b1);
        checks++;
        if (bus.req_ready !== 4'b0001 || bus.out_src !== 2'd3 || bus.out_data !== 8'hD3) begin
            errors++;
            $display("FAIL wrap_second ready=%b src=%0d data=%h required 0001 3 d3",
                     bus.req_ready, bus.out_src, bus.out_data);
        end
        tick();
        settle(4'b0000, '0, 1'b1);
        tick();
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 3; k++) begin
            settle(4'b1111, {8'h04, 8'h03, 8'h02, 8'h01}, 1'b1);
            tick();
        end
        settle(4'b1111, {8'h04, 8'h03, 8'h02, 8'h01}, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_precond valid=%b required 1", bus.out_valid);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL areset_immediate valid=%b ready=%b required 0 0000", bus.out_valid, bus.req_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        settle(4'b1010, {8'h0A, 8'h0, 8'h0B, 8'h0}, 1'b1);
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL areset_first_grant ready=%b required 0010", bus.req_ready);
        end
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0]   v;
        logic [N*W-1:0] d;
        logic           r;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            v = N'($urandom_range(0, 15));
            d = {$urandom()};
            r = ($urandom_range(0, 3) != 0);
            settle(v, d, r);
            checks++;
            if (bus.req_ready !== exp_ready || bus.out_valid !== exp_valid) begin
                errors++;
                $display("FAIL rand_ctrl cyc=%0d ready=%b valid=%b required %b %b",
                         k, bus.req_ready, bus.out_valid, exp_ready, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (bus.out_data !== exp_data || bus.out_src !== exp_src) begin
                    errors++;
                    $display("FAIL rand_data cyc=%0d data=%h src=%0d required %h %0d",
                             k, bus.out_data, bus.out_src, exp_data, exp_src);
                end
            end
            tick();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
